// File: rtl/md_pkg.sv
// Shared constants for the multiply/divide sequencer: ALU opcodes, MD op
// encodings and the controller state type.
package md_pkg;

  localparam int unsigned ALU_OP_W = 4;
  localparam int unsigned MD_OP_W  = 2;

  localparam logic [ALU_OP_W-1:0] ALU_AND = 4'b0000;
  localparam logic [ALU_OP_W-1:0] ALU_OR  = 4'b0001;
  localparam logic [ALU_OP_W-1:0] ALU_ADD = 4'b0010;
  localparam logic [ALU_OP_W-1:0] ALU_XOR = 4'b0011;
  localparam logic [ALU_OP_W-1:0] ALU_SUB = 4'b0110;
  localparam logic [ALU_OP_W-1:0] ALU_SLT = 4'b0111;
  localparam logic [ALU_OP_W-1:0] ALU_NOR = 4'b1100;

  // Bit 1 selects divide, bit 0 selects unsigned.
  localparam logic [MD_OP_W-1:0] MD_MULT  = 2'b00;
  localparam logic [MD_OP_W-1:0] MD_MULTU = 2'b01;
  localparam logic [MD_OP_W-1:0] MD_DIV   = 2'b10;
  localparam logic [MD_OP_W-1:0] MD_DIVU  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ITER = 2'd1,
    ST_FIX  = 2'd2
  } md_state_e;

endpackage

// File: rtl/md_sign_fix.sv
// Final sign correction of the magnitude result: 64-bit negate for products,
// quotient/remainder sign rules for divides, pass-through for divide by zero.
module md_sign_fix
  import md_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            is_div_i,
  input  logic            neg_q_i,
  input  logic            neg_r_i,
  input  logic            div0_i,
  input  logic [XLEN-1:0] acc_hi_i,
  input  logic [XLEN-1:0] acc_lo_i,
  output logic [XLEN-1:0] hi_c_o,
  output logic [XLEN-1:0] lo_c_o
);

  localparam int unsigned PW = 2 * XLEN;

  logic [PW-1:0] prod_neg;

  assign prod_neg = ~{acc_hi_i, acc_lo_i} + PW'(1);

  always_comb begin
    hi_c_o = acc_hi_i;
    lo_c_o = acc_lo_i;
    if (div0_i) begin
      // accumulators were preloaded with the divide-by-zero result
      hi_c_o = acc_hi_i;
      lo_c_o = acc_lo_i;
    end else if (is_div_i) begin
      lo_c_o = neg_q_i ? (~acc_lo_i + XLEN'(1)) : acc_lo_i;
      hi_c_o = neg_r_i ? (~acc_hi_i + XLEN'(1)) : acc_hi_i;
    end else if (neg_q_i) begin
      {hi_c_o, lo_c_o} = prod_neg;
    end
  end

endmodule

// File: rtl/md_sequencer.sv
// Multi-cycle MULT/MULTU/DIV/DIVU controller: drives the shared ALU through
// 32 shift-add or restoring shift-subtract steps and produces HI/LO.
module md_sequencer
  import md_pkg::*;
#(
  parameter int unsigned     XLEN    = 32,
  parameter int unsigned     ITERS   = 32,
  parameter logic [XLEN-1:0] DIV0_LO = 32'hFFFF_FFFF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo,
  output logic [XLEN-1:0] alu_a,
  output logic [XLEN-1:0] alu_b,
  output logic [3:0]      alu_op,
  input  logic [XLEN-1:0] alu_s
);

  localparam int unsigned       CNT_W    = $clog2(ITERS);
  localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(ITERS - 1);

  md_state_e             state_q, state_d;
  logic                  is_div_q, is_div_d;
  logic                  sa_q, sa_d, sb_q, sb_d;
  logic                  div0_q, div0_d;
  logic [XLEN-1:0]       ma_q, ma_d, mb_q, mb_d;
  logic [XLEN-1:0]       acc_hi_q, acc_hi_d, acc_lo_q, acc_lo_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic                  busy_q, busy_d, done_q, done_d;
  logic [XLEN-1:0]       hi_q, hi_d, lo_q, lo_d;
  logic [XLEN-1:0]       alu_a_q, alu_a_d, alu_b_q, alu_b_d;
  logic [ALU_OP_W-1:0]   alu_op_q, alu_op_d;

  logic                  sa_in, sb_in;
  logic [XLEN-1:0]       ma_in, mb_in;
  logic [XLEN-1:0]       r_div;
  logic                  ge, carry;
  logic [XLEN-1:0]       fix_hi_c, fix_lo_c;

  // Operand sign/magnitude capture; the most negative value maps to itself.
  assign sa_in = ~op[0] & a[XLEN-1];
  assign sb_in = ~op[0] & b[XLEN-1];
  assign ma_in = sa_in ? (~a + XLEN'(1)) : a;
  assign mb_in = sb_in ? (~b + XLEN'(1)) : b;

  assign r_div = {acc_hi_q[XLEN-2:0], acc_lo_q[XLEN-1]};
  assign ge    = acc_hi_q[XLEN-1] | (r_div >= mb_q);
  assign carry = alu_s < acc_hi_q;

  md_sign_fix #(
    .XLEN(XLEN)
  ) u_sign_fix (
    .is_div_i (is_div_q),
    .neg_q_i  (sa_q ^ sb_q),
    .neg_r_i  (sa_q),
    .div0_i   (div0_q),
    .acc_hi_i (acc_hi_q),
    .acc_lo_i (acc_lo_q),
    .hi_c_o   (fix_hi_c),
    .lo_c_o   (fix_lo_c)
  );

  always_comb begin
    state_d  = state_q;
    is_div_d = is_div_q;
    sa_d     = sa_q;
    sb_d     = sb_q;
    div0_d   = div0_q;
    ma_d     = ma_q;
    mb_d     = mb_q;
    acc_hi_d = acc_hi_q;
    acc_lo_d = acc_lo_q;
    count_d  = count_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    hi_d     = hi_q;
    lo_d     = lo_q;
    alu_a_d  = '0;
    alu_b_d  = '0;
    alu_op_d = ALU_AND;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          is_div_d = op[1];
          sa_d     = sa_in;
          sb_d     = sb_in;
          ma_d     = ma_in;
          mb_d     = mb_in;
          count_d  = '0;
          busy_d   = 1'b1;
          if (op[1] && (b == '0)) begin
            div0_d   = 1'b1;
            acc_hi_d = a;
            acc_lo_d = DIV0_LO;
            state_d  = ST_FIX;
          end else begin
            div0_d   = 1'b0;
            acc_hi_d = '0;
            acc_lo_d = op[1] ? ma_in : mb_in;
            state_d  = ST_ITER;
          end
        end
      end
      ST_ITER: begin
        if (is_div_q) begin
          acc_hi_d = ge ? alu_s : r_div;
          acc_lo_d = {acc_lo_q[XLEN-2:0], ge};
        end else if (acc_lo_q[0]) begin
          acc_hi_d = {carry, alu_s[XLEN-1:1]};
          acc_lo_d = {alu_s[0], acc_lo_q[XLEN-1:1]};
        end else begin
          acc_hi_d = {1'b0, acc_hi_q[XLEN-1:1]};
          acc_lo_d = {acc_hi_q[0], acc_lo_q[XLEN-1:1]};
        end
        count_d = count_q + CNT_W'(1);
        if (count_q == LAST_CNT) begin
          state_d = ST_FIX;
        end
      end
      ST_FIX: begin
        hi_d    = fix_hi_c;
        lo_d    = fix_lo_c;
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase

    // ALU operands are registered, so they are prepared from next-cycle state.
    if (state_d == ST_ITER) begin
      if (is_div_d) begin
        alu_a_d  = {acc_hi_d[XLEN-2:0], acc_lo_d[XLEN-1]};
        alu_b_d  = mb_d;
        alu_op_d = ALU_SUB;
      end else begin
        alu_a_d  = acc_hi_d;
        alu_b_d  = ma_d;
        alu_op_d = ALU_ADD;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      is_div_q <= 1'b0;
      sa_q     <= 1'b0;
      sb_q     <= 1'b0;
      div0_q   <= 1'b0;
      ma_q     <= '0;
      mb_q     <= '0;
      acc_hi_q <= '0;
      acc_lo_q <= '0;
      count_q  <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      alu_a_q  <= '0;
      alu_b_q  <= '0;
      alu_op_q <= ALU_AND;
    end else begin
      state_q  <= state_d;
      is_div_q <= is_div_d;
      sa_q     <= sa_d;
      sb_q     <= sb_d;
      div0_q   <= div0_d;
      ma_q     <= ma_d;
      mb_q     <= mb_d;
      acc_hi_q <= acc_hi_d;
      acc_lo_q <= acc_lo_d;
      count_q  <= count_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      alu_a_q  <= alu_a_d;
      alu_b_q  <= alu_b_d;
      alu_op_q <= alu_op_d;
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign hi     = hi_q;
  assign lo     = lo_q;
  assign alu_a  = alu_a_q;
  assign alu_b  = alu_b_q;
  assign alu_op = alu_op_q;

endmodule

// File: tb/tb_md_sequencer.sv
// Self-checking bench for md_sequencer: models the shared ALU and checks
// results, latency, busy/done and ALU ownership against 64-bit arithmetic.
module tb_md_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a, b;
  logic        busy, done;
  logic [31:0] hi, lo, alu_a, alu_b, alu_s;
  logic [3:0]  alu_op;

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] exp_hi = '0;
  logic [31:0] exp_lo = '0;

  always #5 clk = ~clk;

  // External ALU model
  assign alu_s = (alu_op == 4'b0010) ? alu_a + alu_b :
                 (alu_op == 4'b0110) ? alu_a - alu_b : (alu_a & alu_b);

  md_sequencer dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .op     (op),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .hi     (hi),
    .lo     (lo),
    .alu_a  (alu_a),
    .alu_b  (alu_b),
    .alu_op (alu_op),
    .alu_s  (alu_s)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference {hi, lo} straight from signed/unsigned 64-bit arithmetic.
  function automatic logic [63:0] ref_md(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    logic signed [63:0] sx, sy, q, r;
    logic [63:0] ux, uy;
    sx = {{32{x[31]}}, x};
    sy = {{32{y[31]}}, y};
    ux = {32'h0, x};
    uy = {32'h0, y};
    case (o)
      2'b00: return sx * sy;
      2'b01: return ux * uy;
      2'b10: begin
        if (y == 32'h0) return {x, 32'hFFFF_FFFF};
        q = sx / sy;
        r = sx % sy;
        return {r[31:0], q[31:0]};
      end
      default: begin
        if (y == 32'h0) return {x, 32'hFFFF_FFFF};
        return {x % y, x / y};
      end
    endcase
  endfunction

  task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                        input int dup_at, input int rst_at);
    logic [63:0] res;
    logic [3:0]  exp_alu;
    int exp_lat, exp_nalu, done_at, ndone, nalu;
    logic busy_ok, hold_ok;
    res      = ref_md(o, x, y);
    exp_alu  = o[1] ? 4'b0110 : 4'b0010;
    exp_lat  = (o[1] && y == 32'h0) ? 1 : 33;
    exp_nalu = (rst_at > 0) ? rst_at + 1 : ((exp_lat == 1) ? 0 : 32);
    done_at  = -1;
    ndone    = 0;
    nalu     = 0;
    busy_ok  = 1'b1;
    hold_ok  = 1'b1;

    @(negedge clk);
    start = 1'b1; op = o; a = x; b = y;
    @(posedge clk); #1;
    start = 1'b0; a = $urandom; b = $urandom;
    if (alu_op == exp_alu) nalu++;
    if (busy !== 1'b1) busy_ok = 1'b0;
    if (hi !== exp_hi || lo !== exp_lo) hold_ok = 1'b0;

    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      start = 1'b0;
      if (!done && done_at < 0 && (hi !== exp_hi || lo !== exp_lo)) hold_ok = 1'b0;
      if (done) begin
        ndone++;
        if (done_at < 0) done_at = k;
      end
      if (alu_op == exp_alu) nalu++;
      if (rst_at == 0) begin
        if (k < exp_lat && busy !== 1'b1) busy_ok = 1'b0;
        if (k >= exp_lat && busy !== 1'b0) busy_ok = 1'b0;
      end
      if (k == dup_at) begin
        start = 1'b1; op = 2'($urandom); a = $urandom; b = $urandom;
      end
      if (k == rst_at) begin
        rst_n = 1'b0;
        #1;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_hilo", {hi, lo}, 64'd0);
        check("rst_alu", {alu_a, alu_b}, 64'd0);
        check("rst_aluop", 64'(alu_op), 64'd0);
        #2 rst_n = 1'b1;
        exp_hi = '0;
        exp_lo = '0;
      end
    end

    if (rst_at == 0) begin
      check("done_lat", 64'(done_at), 64'(exp_lat));
      check("done_cnt", 64'(ndone), 64'd1);
      check("result", {hi, lo}, res);
      exp_hi = res[63:32];
      exp_lo = res[31:0];
    end else begin
      check("no_done", 64'(ndone), 64'd0);
      check("busy_after_rst", 64'(busy), 64'd0);
    end
    check("alu_cycles", 64'(nalu), 64'(exp_nalu));
    check("busy_seq", 64'(busy_ok), 64'd1);
    check("hilo_hold", 64'(hold_ok), 64'd1);
    check("alu_idle", {alu_a, alu_b}, 64'd0);
    check("aluop_idle", 64'(alu_op), 64'd0);
  endtask

  function automatic logic [31:0] pick_val();
    case ($urandom_range(0, 5))
      0: return 32'h8000_0000;
      1: return 32'hFFFF_FFFF;
      2: return 32'h0;
      3: return 32'(1);
      default: return $urandom;
    endcase
  endfunction

  initial begin
    rst_n = 1'b0; start = 1'b0; op = 2'b00; a = '0; b = '0;
    repeat (2) @(negedge clk);
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_done", 64'(done), 64'd0);
    check("reset_hilo", {hi, lo}, 64'd0);
    check("reset_alu", {alu_a, alu_b}, 64'd0);
    check("reset_aluop", 64'(alu_op), 64'd0);
    rst_n = 1'b1;

    run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0);
    run_op(2'b00, 32'hFFFF_FFFD, 32'd7, 0, 0);
    run_op(2'b11, 32'd100, 32'd7, 0, 0);
    run_op(2'b10, 32'hFFFF_FFF9, 32'd2, 0, 0);
    run_op(2'b10, 32'h1234_5678, 32'h0, 0, 0);
    run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0);
    run_op(2'b00, 32'h8000_0000, 32'h8000_0000, 0, 0);
    run_op(2'b00, 32'd5, 32'd6, 10, 0);
    run_op(2'b10, 32'd1000, 32'd7, 0, 15);
    run_op(2'b11, 32'd9, 32'd3, 0, 0);

    for (int i = 0; i < 40; i++) begin
      run_op(2'($urandom), pick_val(), pick_val(), 0, 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
